reg_writeback_ctrl: RTL and testbench
=====================================

REG_WRITEBACK_CTRL -- requirements
Module: reg_writeback_ctrl

Interface
REQ-001 Parameter: DEPTH, 4, writeback queue entries (power of two, at least 2).
REQ-002 clock  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 mem_valid  in  1  load-result writeback request.
REQ-005 mem_ready  out  1  request accepted when mem_valid and mem_ready are both high at a rising edge.
REQ-006 mem_addr  in  5  destination register index for the load result.
REQ-007 mem_data  in  32  load result value.
REQ-008 alu_valid, alu_ready, alu_addr, alu_data  in/out/in/in  1/1/5/32  ALU writeback request, same handshake rules as the mem port.
REQ-009 rsv_valid  in  1  reserve a destination register at instruction issue.
REQ-010 rsv_addr  in  5  register index to reserve.
REQ-011 rf_we  out  1  register-file write enable.
REQ-012 rf_waddr  out  5  register-file write address.
REQ-013 rf_wdata  out  32  register-file write data.
REQ-014 busy  out  32  scoreboard; bit i set means a write to register i is pending.
REQ-015 fifo_count  out  $clog2(DEPTH)+1  number of queued entries.

Function
REQ-016 Shared FIFO of {addr, data} entries; one entry drains per cycle when the FIFO is non-empty.
REQ-017 mem_ready shall equal (fifo_count < DEPTH) and not reset; it is computed from registered count only, with no credit for a same-cycle pop.
REQ-018 alu_ready shall be high when fifo_count <= DEPTH-2, or when fifo_count == DEPTH-1 and mem_valid is low; it is low during reset.
REQ-019 When both ports are accepted in the same edge, the mem entry is enqueued ahead of the alu entry (mem has priority).
REQ-020 Latency: an entry accepted at edge E into an empty FIFO is popped at edge E+1; rf_we, rf_waddr and rf_wdata are registered and valid from E+1 to E+2.
REQ-021 rf_we shall be high for exactly one cycle per popped entry whose addr != 0.
REQ-022 Entries with addr == 0 are popped and dropped: rf_we stays low and rf_waddr/rf_wdata hold their previous values.
REQ-023 Push and pop in the same edge shall both take effect; fifo_count changes by (pushes - pops).
REQ-024 Entries drain in strict FIFO order; pointers wrap modulo DEPTH.
REQ-025 A rsv_valid pulse with rsv_addr != 0 sets busy[rsv_addr] at the next edge.
REQ-026 A cycle with rf_we high clears busy[rf_waddr] at the next edge.
REQ-027 If a set and a clear target the same bit at the same edge, the set wins.
REQ-028 busy[0] shall always read 0.
REQ-029 Requests arriving while the FIFO is full are not accepted; the requester must hold valid, addr and data stable until accepted.

Reset
REQ-030 Reset clears pointers, fifo_count=0, busy=0, rf_we=0, rf_waddr=0 and rf_wdata=0.
REQ-031 Reset asserted mid-operation discards queued entries; no rf_we pulse occurs in the cycle following the reset edge.
REQ-032 Reset has priority over handshakes, pops and scoreboard updates at the same edge.

Structure
REQ-033 Shared package reg_wb_pkg holds REG_ADDR_W=5, DATA_W=32, NUM_REGS=32 and the wb_entry_t struct {addr, data}.
REQ-034 The storage shall be the sub-module wb_fifo (DEPTH, push/pop, full/empty/count); the arbitration and scoreboard logic stays in the top module.

Verification
REQ-035 Single mem write: mem addr=5, data=0xDEADBEEF accepted at edge E -> rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF during E+1..E+2, for exactly one cycle.
REQ-036 Simultaneous requests (mem r3=0x11, alu r4=0x22) into an empty FIFO -> writes issue in the order r3 then r4 on consecutive cycles.
REQ-037 Fill: hold both valids for 4 edges with DEPTH=4 -> mem_ready low at count 4, alu_ready low at count 3 while mem_valid is high, no entry lost, 4 writes issue in order.
REQ-038 Address 0: alu addr=0, data=0x55 -> no rf_we pulse, fifo_count returns to 0, busy stays 0.
REQ-039 Scoreboard: rsv r7, then mem write r7 -> busy[7]=1 until the edge after rf_we, then 0; a re-reservation of r7 in the clear cycle leaves busy[7]=1.
REQ-040 Reset mid-operation: 3 entries queued, then reset asserted -> fifo_count=0, busy=0, rf_we stays 0 afterwards.

Source files
------------

// File: rtl/reg_wb_pkg.sv
// Shared types and widths for the register writeback path.
package reg_wb_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Writeback queue storage: up to two pushes and one pop per cycle.
// push1 is only meaningful together with push0 (it lands one slot behind it).
module wb_fifo
  import reg_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push0,
  input  wb_entry_t              push0_data,
  input  logic                   push1,
  input  wb_entry_t              push1_data,
  input  logic                   pop,
  output wb_entry_t              head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  wb_entry_t       mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            pop_en;

  // Pointer and occupancy next-state; pointers wrap naturally (DEPTH is a power of two).
  always_comb begin
    pop_en   = pop & (count_q != '0);
    wr_ptr_d = wr_ptr_q + PtrW'(push0) + PtrW'(push1);
    rd_ptr_d = rd_ptr_q + PtrW'(pop_en);
    count_d  = count_q + CntW'(push0) + CntW'(push1) - CntW'(pop_en);
  end

  // Pointer and count registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents need no reset since count gates visibility.
  always_ff @(posedge clock) begin
    if (push0) mem_q[wr_ptr_q] <= push0_data;
    if (push1) mem_q[wr_ptr_q + PtrW'(1)] <= push1_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/reg_writeback_ctrl.sv
// Arbitrates load and ALU writebacks into a shared queue, drains one entry
// per cycle to the register file and tracks pending destinations in a scoreboard.
module reg_writeback_ctrl
  import reg_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   mem_valid,
  output logic                   mem_ready,
  input  logic [REG_ADDR_W-1:0]  mem_addr,
  input  logic [DATA_W-1:0]      mem_data,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [REG_ADDR_W-1:0]  alu_addr,
  input  logic [DATA_W-1:0]      alu_data,
  input  logic                   rsv_valid,
  input  logic [REG_ADDR_W-1:0]  rsv_addr,
  output logic                   rf_we,
  output logic [REG_ADDR_W-1:0]  rf_waddr,
  output logic [DATA_W-1:0]      rf_wdata,
  output logic [NUM_REGS-1:0]    busy,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic                  mem_acc, alu_acc;
  logic                  push0, push1, pop;
  wb_entry_t             push0_data, push1_data, mem_entry, alu_entry, head;
  logic                  fifo_full, fifo_empty;
  logic                  rf_we_q, rf_we_d;
  logic [REG_ADDR_W-1:0] rf_waddr_q;
  logic [DATA_W-1:0]     rf_wdata_q;
  logic [NUM_REGS-1:0]   busy_q, busy_d;

  // Handshake and push steering. Readiness uses the registered count only, so
  // the ALU port is held back when mem takes the last free slot.
  always_comb begin
    mem_ready  = ~reset & ~fifo_full;
    alu_ready  = ~reset & ((fifo_count <= CntW'(DEPTH - 2)) ||
                           ((fifo_count == CntW'(DEPTH - 1)) && !mem_valid));
    mem_acc    = mem_valid & mem_ready;
    alu_acc    = alu_valid & alu_ready;
    mem_entry  = '{addr: mem_addr, data: mem_data};
    alu_entry  = '{addr: alu_addr, data: alu_data};
    push0      = mem_acc | alu_acc;
    push0_data = mem_acc ? mem_entry : alu_entry;
    push1      = mem_acc & alu_acc;
    push1_data = alu_entry;
    pop        = ~fifo_empty;
  end

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_wb_fifo (
    .clock      (clock),
    .reset      (reset),
    .push0      (push0),
    .push0_data (push0_data),
    .push1      (push1),
    .push1_data (push1_data),
    .pop        (pop),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  // Scoreboard next-state: clear on write, set on reserve (set wins), r0 never busy.
  always_comb begin
    rf_we_d = pop && (head.addr != '0);
    busy_d  = busy_q;
    if (rf_we_q) busy_d[rf_waddr_q] = 1'b0;
    if (rsv_valid && (rsv_addr != '0)) busy_d[rsv_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Register-file write port and scoreboard registers; r0 entries are dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      busy_q     <= '0;
    end else begin
      rf_we_q <= rf_we_d;
      busy_q  <= busy_d;
      if (rf_we_d) begin
        rf_waddr_q <= head.addr;
        rf_wdata_q <= head.data;
      end
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Scoreboard bench for reg_writeback_ctrl: directed scenarios then random traffic.
module tb_reg_writeback_ctrl;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clock, reset;
  logic          mem_valid, mem_ready, alu_valid, alu_ready, rsv_valid, rf_we;
  logic [4:0]    mem_addr, alu_addr, rsv_addr, rf_waddr;
  logic [31:0]   mem_data, alu_data, rf_wdata, busy;
  logic [CW-1:0] fifo_count;

  reg_writeback_ctrl #(
    .DEPTH (DEPTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_addr   (alu_addr),
    .alu_data   (alu_data),
    .rsv_valid  (rsv_valid),
    .rsv_addr   (rsv_addr),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  ent_t        mq[$];     // entries sitting in the queue
  ent_t        exp_q[$];  // register writes the DUT owes the monitor
  logic [31:0] busy_m  = '0;
  logic        we_m    = 1'b0;
  logic [4:0]  waddr_m = '0;
  logic [31:0] wdata_m = '0;

  // Requester state (held stable until accepted)
  logic        m_pend = 0, a_pend = 0, r_v = 0, rst_v = 0;
  logic [4:0]  m_a = 0, a_a = 0, r_a = 0;
  logic [31:0] m_d = 0, a_d = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: drive, check visible state against the model, then advance the model.
  task automatic step();
    int   cnt;
    logic exp_mr, exp_ar, macc, aacc, new_we;
    logic [31:0] nb;
    ent_t e;
    @(negedge clock);
    reset     = rst_v;
    mem_valid = m_pend; mem_addr = m_a; mem_data = m_d;
    alu_valid = a_pend; alu_addr = a_a; alu_data = a_d;
    rsv_valid = r_v;    rsv_addr = r_a;
    #1;
    cnt    = mq.size();
    exp_mr = !rst_v && (cnt < DEPTH);
    exp_ar = !rst_v && ((cnt <= DEPTH - 2) || (cnt == DEPTH - 1 && !m_pend));
    chk("mem_ready", mem_ready, exp_mr);
    chk("alu_ready", alu_ready, exp_ar);
    chk("fifo_count", fifo_count, cnt);
    chk("busy", busy, busy_m);
    chk("rf_waddr", rf_waddr, waddr_m);
    chk("rf_wdata", rf_wdata, wdata_m);
    @(posedge clock);
    macc = m_pend && exp_mr;
    aacc = a_pend && exp_ar;
    if (rst_v) begin
      mq.delete();
      busy_m = '0; we_m = 0; waddr_m = '0; wdata_m = '0;
    end else begin
      nb = busy_m;
      if (we_m) nb[waddr_m] = 1'b0;
      if (r_v && r_a != 0) nb[r_a] = 1'b1;
      nb[0] = 1'b0;
      new_we = 1'b0;
      if (mq.size() > 0) begin
        e = mq.pop_front();
        if (e.a != 0) begin
          new_we = 1'b1; waddr_m = e.a; wdata_m = e.d;
          exp_q.push_back(e);
        end
      end
      if (macc) mq.push_back('{a: m_a, d: m_d});
      if (aacc) mq.push_back('{a: a_a, d: a_d});
      busy_m = nb;
      we_m   = new_we;
    end
    if (macc) m_pend = 0;
    if (aacc) a_pend = 0;
    r_v   = 0;
    rst_v = 0;
  endtask

  task automatic wait_accept();
    for (int i = 0; i < 20 && (m_pend || a_pend); i++) step();
    if (m_pend || a_pend) chk("accept_timeout", {m_pend, a_pend}, 2'b00);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  // Monitor: every rf_we pulse must match the oldest owed write, and none may be late.
  initial begin
    ent_t e;
    forever begin
      @(negedge clock);
      if (rf_we) begin
        if (exp_q.size() == 0) chk("rf_we_spurious", rf_we, 1'b0);
        else begin
          e = exp_q.pop_front();
          chk("wr_addr", rf_waddr, e.a);
          chk("wr_data", rf_wdata, e.d);
        end
      end else if (exp_q.size() != 0) begin
        chk("rf_we_missing", rf_we, 1'b1);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    reset = 1; mem_valid = 0; alu_valid = 0; rsv_valid = 0;
    mem_addr = 0; alu_addr = 0; rsv_addr = 0; mem_data = 0; alu_data = 0;
    repeat (2) @(posedge clock);

    // Reset state
    idle(1);

    // Single load write
    m_pend = 1; m_a = 5; m_d = 32'hDEAD_BEEF;
    wait_accept(); idle(4);

    // Simultaneous requests: mem first
    m_pend = 1; m_a = 3; m_d = 32'h11;
    a_pend = 1; a_a = 4; a_d = 32'h22;
    wait_accept(); idle(4);

    // Fill: keep both ports requesting for several edges
    for (int k = 0; k < 4; k++) begin
      if (!m_pend) begin m_pend = 1; m_a = 5'(8 + k); m_d = 32'h100 + k; end
      if (!a_pend) begin a_pend = 1; a_a = 5'(16 + k); a_d = 32'h200 + k; end
      step();
    end
    wait_accept(); idle(6);

    // Address 0 is dropped
    a_pend = 1; a_a = 0; a_d = 32'h55;
    wait_accept(); idle(3);

    // Scoreboard: reserve r7, write r7, re-reserve in the clear cycle
    r_v = 1; r_a = 7; step();
    m_pend = 1; m_a = 7; m_d = 32'h77;
    wait_accept();
    step();                     // pop edge; rf_we visible next cycle
    r_v = 1; r_a = 7; step();   // clear and set collide: set wins
    idle(2);
    m_pend = 1; m_a = 7; m_d = 32'h78;
    wait_accept(); idle(4);     // now busy[7] clears

    // Reset mid-operation with entries queued
    r_v = 1; r_a = 9;
    m_pend = 1; m_a = 1; m_d = 32'hA1; a_pend = 1; a_a = 2; a_d = 32'hA2;
    step();
    m_pend = 1; m_a = 3; m_d = 32'hA3; a_pend = 1; a_a = 4; a_d = 32'hA4;
    step();
    m_pend = 0; a_pend = 0;
    rst_v = 1; step();
    idle(4);

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      if (!m_pend && ($urandom % 3 == 0)) begin
        m_pend = 1; m_a = ($urandom % 8 == 0) ? 5'd0 : 5'($urandom); m_d = $urandom;
      end
      if (!a_pend && ($urandom % 3 == 0)) begin
        a_pend = 1; a_a = ($urandom % 8 == 0) ? 5'd0 : 5'($urandom); a_d = $urandom;
      end
      if ($urandom % 4 == 0) begin r_v = 1; r_a = 5'($urandom); end
      if ($urandom % 80 == 0) rst_v = 1;
      step();
    end
    wait_accept(); idle(8);
    chk("owed_writes", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
